// File: rtl/cart_bs_resolver.sv
// Cart bank-switch resolver: tracks loaded ROM size during a cart download,
// waits for the byte-pattern detector to settle, then registers the final
// bank-switch scheme and Superchip enable for the mapper.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   dl_active, dl_wr    download level and byte-write strobe
//   dl_addr[16:0]       byte address of current write
//   ext_bs[3:0]         scheme from file extension (0 = none)
//   det_bs[3:0], det_sc detector scheme code and Superchip flag
//   bs_out, sc_out      resolved scheme and Superchip enable
//   rom_size[16:0]      loaded size in bytes (saturating)
//   valid, done         result valid (held), one-cycle completion pulse
module cart_bs_resolver #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [16:0] dl_addr,
  input  logic [3:0]  ext_bs,
  input  logic [3:0]  det_bs,
  input  logic        det_sc,
  output logic [3:0]  bs_out,
  output logic        sc_out,
  output logic [16:0] rom_size,
  output logic        valid,
  output logic        done
);

  localparam int unsigned SIZE_W = 17;
  localparam int unsigned BS_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RESOLVE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZE_W-1:0]   rom_size_q, rom_size_d;
  logic [BS_W-1:0]     bs_q, bs_d;
  logic                sc_q, sc_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                wr_en_c;
  logic [SIZE_W:0]     wr_end_c;
  logic [SIZE_W-1:0]   wr_size_c;
  logic [BS_W-1:0]     bs_res_c;
  logic                sc_res_c;

  // End address of the current write, saturated to 17 bits; writes only count while downloading.
  assign wr_en_c   = dl_active & dl_wr;
  assign wr_end_c  = {1'b0, dl_addr} + (SIZE_W+1)'(1);
  assign wr_size_c = wr_end_c[SIZE_W] ? {SIZE_W{1'b1}} : wr_end_c[SIZE_W-1:0];

  // Scheme resolution: extension override, then size rules gating the detector.
  always_comb begin
    bs_res_c = det_bs;
    if (ext_bs != BS_W'(0)) begin
      bs_res_c = ext_bs;
    end else if (rom_size_q <= SIZE_W'(4096)) begin
      bs_res_c = (det_bs == BS_W'(9)) ? BS_W'(9) : BS_W'(0);
    end else begin
      case (rom_size_q)
        SIZE_W'(8192): begin
          if (det_bs == BS_W'(3) || det_bs == BS_W'(4) || det_bs == BS_W'(5)) bs_res_c = det_bs;
          else                                                                 bs_res_c = BS_W'(1);
        end
        SIZE_W'(10240),
        SIZE_W'(10495): bs_res_c = BS_W'(7);
        SIZE_W'(12288): bs_res_c = BS_W'(8);
        SIZE_W'(16384): begin
          if (det_bs == BS_W'(5) || det_bs == BS_W'(12)) bs_res_c = det_bs;
          else                                           bs_res_c = BS_W'(2);
        end
        SIZE_W'(32768): bs_res_c = (det_bs == BS_W'(5)) ? BS_W'(5) : BS_W'(6);
        SIZE_W'(65536): bs_res_c = (det_bs == BS_W'(5)) ? BS_W'(5) : BS_W'(13);
        default:        bs_res_c = det_bs;
      endcase
    end
  end

  // Superchip RAM only exists on F8/F6/F4 boards.
  assign sc_res_c = det_sc & ((bs_res_c == BS_W'(1)) | (bs_res_c == BS_W'(2)) |
                              (bs_res_c == BS_W'(6)));

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_size_d = rom_size_q;
    bs_d       = bs_q;
    sc_d       = sc_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (dl_active) begin
          state_d    = S_LOAD;
          rom_size_d = wr_en_c ? wr_size_c : SIZE_W'(0);
          bs_d       = BS_W'(0);
          sc_d       = 1'b0;
          valid_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (!dl_active) begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else if (wr_en_c && (wr_size_c > rom_size_q)) begin
          rom_size_d = wr_size_c;
        end
      end
      S_SETTLE: begin
        // A new download before the result is taken restarts size tracking.
        if (dl_active) begin
          state_d    = S_LOAD;
          cnt_d      = CNT_W'(0);
          rom_size_d = wr_en_c ? wr_size_c : SIZE_W'(0);
        end else if (cnt_q == CNT_W'(0)) begin
          state_d = S_RESOLVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESOLVE: begin
        bs_d    = bs_res_c;
        sc_d    = sc_res_c;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rom_size_q <= '0;
      bs_q       <= '0;
      sc_q       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_size_q <= rom_size_d;
      bs_q       <= bs_d;
      sc_q       <= sc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign bs_out   = bs_q;
  assign sc_out   = sc_q;
  assign rom_size = rom_size_q;
  assign valid    = valid_q;
  assign done     = done_q;

endmodule

// File: doc/cart_bs_resolver.md
# cart_bs_resolver

Resolves the final 2600 bank-switch scheme and Superchip flag once a cartridge download completes. It sits directly downstream of the cart byte-pattern detector. It tracks the loaded ROM size from the download address stream, waits for the detector outputs to settle, and combines three inputs into one registered result for the cart mapper: the file-extension override, the detector's scheme code and Superchip flag, and size-based rules.

## Interface
- SETTLE_CYCLES, default 4: cycles waited after download end before sampling detector outputs; legal range 2..15.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  cart download in progress; level.
- dl_wr  in  1  byte-write strobe; same strobe that drives the detector enable.
- dl_addr  in  17  byte address of the current write.
- ext_bs  in  4  scheme from file extension; 0 = none.
- det_bs  in  4  detector scheme code; 0 = none.
- det_sc  in  1  detector Superchip flag.
- bs_out  out  4  resolved scheme code.
- sc_out  out  1  resolved Superchip enable.
- rom_size  out  17  loaded size in bytes, saturating.
- valid  out  1  result valid; held until next download starts.
- done  out  1  one-cycle pulse when valid rises.

Scheme codes: 0 = 2K/4K, 1 = F8, 2 = F6, 3 = FE, 4 = E0, 5 = 3F, 6 = F4, 7 = P2, 8 = FA, 9 = CV, 11 = UA, 12 = E7, 13 = F0, 14 = 32.

## Operation
- FSM states: IDLE, LOAD, SETTLE, RESOLVE, DONE. Reset state is IDLE.
- IDLE or DONE, on dl_active=1: go to LOAD. Entry clears rom_size, valid, bs_out and sc_out.
- LOAD:
  - Each dl_wr=1: if dl_addr+1 > rom_size, rom_size <= dl_addr+1.
  - Addition is 18-bit; saturate rom_size at 17'h1FFFF.
  - dl_wr while dl_active=0 is ignored in every state.
- LOAD, on dl_active=0: go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
- SETTLE:
  - Decrement the counter each cycle; at 0, go to RESOLVE.
  - dl_active=1 during SETTLE aborts back to LOAD and clears rom_size.
- RESOLVE, single cycle. Sample det_bs and det_sc and compute bs:
  - ext_bs != 0: bs = ext_bs.
  - rom_size <= 4096: bs = 9 if det_bs==9, else 0.
  - rom_size == 8192: bs = det_bs if det_bs ∈ {3,4,5}, else 1.
  - rom_size ∈ {10240, 10495}: bs = 7.
  - rom_size == 12288: bs = 8.
  - rom_size == 16384: bs = det_bs if det_bs ∈ {5,12}, else 2.
  - rom_size == 32768: bs = 5 if det_bs==5, else 6.
  - rom_size == 65536: bs = 5 if det_bs==5, else 13.
  - Any other size: bs = det_bs.
- Superchip: sc = det_sc AND bs ∈ {1,2,6}.
- RESOLVE registers bs_out and sc_out, then goes to DONE.
- DONE: valid=1 and outputs stable until dl_active rises.

## Timing
- Reset values: bs_out=0, sc_out=0, rom_size=0, valid=0, done=0, FSM=IDLE, settle counter=0.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous); there is no partial result.
- dl_active falls at edge N:
  - SETTLE occupies edges N+1..N+SETTLE_CYCLES.
  - RESOLVE at N+SETTLE_CYCLES+1.
  - bs_out, sc_out, valid and done visible after edge N+SETTLE_CYCLES+2.
- done is high exactly one cycle. valid stays high.
- dl_wr coincident with dl_active falling at the same edge: ignored (dl_active already 0).
- dl_active rising in DONE: valid, bs_out, sc_out and rom_size clear on the next edge; done=0.
- Download with zero writes: rom_size=0, bs_out=0 (or ext_bs), sc_out=0.
- det_bs and det_sc are sampled only in RESOLVE; changes afterwards have no effect.

## Test plan
- 8K load (addr 0..0x1FFF), ext_bs=0, det_bs=0, det_sc=0 -> rom_size=8192, bs_out=1, sc_out=0, valid high SETTLE_CYCLES+2 cycles after dl_active falls, done one cycle.
- 8K load, det_bs=4 -> bs_out=4. 8K load, det_bs=12 -> bs_out=1 (E7 rejected at 8K).
- 32K load, det_bs=0, det_sc=1 -> bs_out=6, sc_out=1. Same load with ext_bs=5 -> bs_out=5, sc_out=0.
- 12K load -> bs_out=8. 10240-byte load -> bs_out=7. 4K load, det_bs=9 -> bs_out=9.
- dl_active re-asserted on the 2nd SETTLE cycle; second load of 16K, det_bs=0 -> no done pulse for the first load; final bs_out=2, rom_size=16384.
- reset_n low mid-LOAD at addr 0x0800 -> all outputs 0 asynchronously. After release, a full 4K load -> bs_out=0, rom_size=4096, valid=1.
